opcode_frame_tx: RTL and testbench
==================================

// Module: opcode_frame_tx
// PURPOSE
//  Nibble-stream frame transmitter for the opcode link. Accepts one BYTE_NUM-byte
//  word per frame and serialises it as a 4-bit stream with strobes. Each frame is
//  the preamble nibbles 5,5,D,5 followed by the payload, MSB byte first and high
//  nibble first. Sits on the transmit side, feeding the link that the nibble opcode
//  receiver decodes.
// PARAMETERS
//  BYTE_NUM  2  payload bytes per frame (>=1); frame = 4 + 2*BYTE_NUM nibbles
//  NIB_GAP   0  idle cycles (dout_vld=0) inserted between consecutive nibbles
//  IFG       4  idle cycles after the last nibble before rdy rises again
// PORTS
//  clk       in   1             system clock, all logic on posedge
//  rst_n     in   1             asynchronous active-low reset
//  din       in   8*BYTE_NUM    payload word, captured on acceptance
//  din_vld   in   1             payload valid; accepted only when rdy=1
//  rdy       out  1             1 = idle, a din_vld this cycle starts a frame
//  dout      out  4             nibble out; forced 0 whenever dout_vld=0
//  dout_vld  out  1             one-cycle strobe per nibble
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, dout=0, dout_vld=0, rdy=1, counters=0.
//  FSM states:
//   IDLE -> SEND on din_vld && rdy.
//   SEND -> IFG after the last nibble strobe (goes directly to IDLE if IFG=0).
//   IFG  -> IDLE after IFG cycles.
//  rdy = (state==IDLE); decoded from the state register, no din_vld path.
//  Acceptance:
//   - din is latched into a {16'h55D5, din} shift register on the accepting edge.
//   - din/din_vld are ignored while rdy=0; there is no queueing, the word is dropped.
//  Timing (accepting edge at end of cycle k):
//   - Nibble j (j=0..L, L=3+2*BYTE_NUM) is driven with dout_vld=1 in cycle
//     k+1+j*(NIB_GAP+1).
//   - dout_vld=0 and dout=0 in all gap cycles.
//   - rdy is 1 again in cycle k+2+L*(NIB_GAP+1)+IFG.
//  Counters:
//   - cnt_gap counts 0..NIB_GAP within each nibble slot.
//   - cnt_nib counts 0..L and increments at the end of cnt_gap.
//   - end of cnt_nib moves SEND to IFG/IDLE; cnt_ifg counts 0..IFG-1.
//   - All counters return to 0 at their end; no wrap beyond the frame.
//  dout and dout_vld are registered outputs; nibble order is the shift register MSB first.
//  Back-to-back frames: with din_vld held high, the next frame is accepted in the first
//  rdy=1 cycle. Minimum inter-frame spacing is therefore IFG+1 cycles with no strobe.
//  Reset mid-frame: the frame is aborted, outputs go to reset values immediately, and
//  nothing is resumed. The next accepted word sends a full preamble.
//  Width rules: cnt_nib is wide enough for L; with NIB_GAP=0 and IFG=0, the cnt_gap and
//  cnt_ifg logic must still synthesise legally (guard with generate or width max(1,..)).
// TESTING
//  1 Reset, then idle: dout=0, dout_vld=0, rdy=1 and held; no strobes.
//  2 BYTE_NUM=2, NIB_GAP=0, IFG=4, din=16'hA13C accepted in cycle k:
//    -> dout 5,5,D,5,A,1,3,C in cycles k+1..k+8, then rdy=1 in cycle k+13.
//  3 Same word with NIB_GAP=2: strobes in cycles k+1, k+4, ..., k+22 with the same nibble
//    order; dout=0 in gap cycles.
//  4 din=16'hFFFF pulsed while rdy=0 mid-frame -> ignored; only the A13C frame is sent,
//    with no F nibbles.
//  5 din_vld held high with 16'h1234 then 16'h5678: two complete frames, gap of exactly
//    IFG+1 cycles without a strobe between them.
//  6 rst_n low after 3rd nibble: dout_vld=0 in the same cycle. After release, rdy=1 and the
//    next word 16'h00FF gives 5,5,D,5,0,0,F,F. Loopback into the receiver yields bytes 00, FF.

Source files
------------

// File: rtl/opcode_frame_tx_if.sv
// Payload-in / nibble-out bus of the opcode frame transmitter.
// The slave modport is the transmitter itself; the master modport is the word source and link sink.
interface opcode_frame_tx_if #(
   parameter int BYTE_NUM = 2
);
   logic [8*BYTE_NUM-1:0] din;
   logic                  din_vld;
   logic                  rdy;
   logic [3:0]            dout;
   logic                  dout_vld;

   modport master (
      output din, din_vld,
      input  rdy, dout, dout_vld
   );

   modport slave (
      input  din, din_vld,
      output rdy, dout, dout_vld
   );
endinterface

// File: rtl/opcode_frame_tx.sv
// Serialises one BYTE_NUM-byte word per frame as preamble 5,5,D,5 plus payload nibbles,
// MSB first, with optional idle cycles between nibbles and an inter-frame gap.
module opcode_frame_tx #(
   parameter int BYTE_NUM = 2,
   parameter int NIB_GAP  = 0,
   parameter int IFG      = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   opcode_frame_tx_if.slave    bus
);
   localparam int L     = 3 + 2*BYTE_NUM;
   localparam int SR_W  = 16 + 8*BYTE_NUM;
   localparam int NIB_W = $clog2(L + 1);
   localparam int GAP_W = (NIB_GAP > 0) ? $clog2(NIB_GAP + 1) : 1;
   localparam int IFG_W = (IFG > 1) ? $clog2(IFG) : 1;

   localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(L);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(NIB_GAP);
   localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'((IFG > 0) ? IFG - 1 : 0);
   localparam logic [15:0]      PREAMBLE = 16'h55D5;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_IFG} state_t;

   state_t            state_reg, state_next;
   logic [SR_W-1:0]   sr_reg, sr_next;
   logic [NIB_W-1:0]  cnt_nib_reg, cnt_nib_next;
   logic [GAP_W-1:0]  cnt_gap_reg, cnt_gap_next;
   logic [IFG_W-1:0]  cnt_ifg_reg, cnt_ifg_next;
   logic [3:0]        dout_reg, dout_next;
   logic              dout_vld_reg, dout_vld_next;
   logic [SR_W-1:0]   frame_word;

   assign frame_word   = {PREAMBLE, bus.din};
   assign bus.rdy      = (state_reg == S_IDLE);
   assign bus.dout     = dout_reg;
   assign bus.dout_vld = dout_vld_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         sr_reg       <= '0;
         cnt_nib_reg  <= '0;
         cnt_gap_reg  <= '0;
         cnt_ifg_reg  <= '0;
         dout_reg     <= 4'h0;
         dout_vld_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         sr_reg       <= sr_next;
         cnt_nib_reg  <= cnt_nib_next;
         cnt_gap_reg  <= cnt_gap_next;
         cnt_ifg_reg  <= cnt_ifg_next;
         dout_reg     <= dout_next;
         dout_vld_reg <= dout_vld_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      sr_next       = sr_reg;
      cnt_nib_next  = cnt_nib_reg;
      cnt_gap_next  = cnt_gap_reg;
      cnt_ifg_next  = cnt_ifg_reg;
      dout_next     = 4'h0;
      dout_vld_next = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (bus.din_vld) begin
               // The first preamble nibble goes out on the accepting edge, so the
               // register keeps only the remaining nibbles.
               dout_next     = frame_word[SR_W-1 -: 4];
               dout_vld_next = 1'b1;
               sr_next       = {frame_word[SR_W-5:0], 4'h0};
               cnt_nib_next  = '0;
               cnt_gap_next  = '0;
               state_next    = S_SEND;
            end
         end
         S_SEND: begin
            if (cnt_nib_reg == NIB_LAST) begin
               // Leave right after the final strobe; no trailing nibble gap.
               cnt_nib_next = '0;
               cnt_gap_next = '0;
               cnt_ifg_next = '0;
               state_next   = (IFG > 0) ? S_IFG : S_IDLE;
            end else if (cnt_gap_reg == GAP_LAST) begin
               cnt_gap_next  = '0;
               cnt_nib_next  = cnt_nib_reg + NIB_W'(1);
               dout_next     = sr_reg[SR_W-1 -: 4];
               dout_vld_next = 1'b1;
               sr_next       = {sr_reg[SR_W-5:0], 4'h0};
            end else begin
               cnt_gap_next = cnt_gap_reg + GAP_W'(1);
            end
         end
         S_IFG: begin
            if (cnt_ifg_reg == IFG_LAST) begin
               cnt_ifg_next = '0;
               state_next   = S_IDLE;
            end else begin
               cnt_ifg_next = cnt_ifg_reg + IFG_W'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_opcode_frame_tx.sv
// Directed bench: dut0 uses NIB_GAP=0, dut1 uses NIB_GAP=2; both BYTE_NUM=2, IFG=4.
module tb_opcode_frame_tx;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   opcode_frame_tx_if #(.BYTE_NUM(2)) bus0 ();
   opcode_frame_tx_if #(.BYTE_NUM(2)) bus1 ();

   opcode_frame_tx #(.BYTE_NUM(2), .NIB_GAP(0), .IFG(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   opcode_frame_tx #(.BYTE_NUM(2), .NIB_GAP(2), .IFG(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int   q0_nib[$], q0_cyc[$], q1_nib[$], q1_cyc[$];
   int   gap_bad0 = 0, gap_bad1 = 0;
   int   rise0 = -1, rise1 = -1;
   logic rdy_prev0 = 1'b1, rdy_prev1 = 1'b1;

   // Link monitor: records every strobed nibble and the cycle rdy comes back.
   always @(negedge clk) begin
      if (bus0.dout_vld) begin
         q0_nib.push_back(int'(bus0.dout));
         q0_cyc.push_back(cyc);
         $display("dut0 nibble %h cycle %0d", bus0.dout, cyc);
      end else if (bus0.dout !== 4'h0) gap_bad0++;
      if (bus1.dout_vld) begin
         q1_nib.push_back(int'(bus1.dout));
         q1_cyc.push_back(cyc);
         $display("dut1 nibble %h cycle %0d", bus1.dout, cyc);
      end else if (bus1.dout !== 4'h0) gap_bad1++;
      if (bus0.rdy && !rdy_prev0) rise0 = cyc;
      if (bus1.rdy && !rdy_prev1) rise1 = cyc;
      rdy_prev0 = bus0.rdy;
      rdy_prev1 = bus1.rdy;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic wait_rdy0();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus0.rdy) break;
      end
      check_eq("wait_rdy0", 32'(bus0.rdy), 32'd1);
   endtask

   task automatic clear_q();
      q0_nib.delete(); q0_cyc.delete(); q1_nib.delete(); q1_cyc.delete();
   endtask

   logic [31:0] exp8;
   logic [63:0] exp16;
   int k;

   initial begin
      bus0.din = '0; bus0.din_vld = 1'b0;
      bus1.din = '0; bus1.din_vld = 1'b0;

      // 1: reset and idle
      @(negedge clk);
      check_eq("rst_rdy", 32'(bus0.rdy), 32'd1);
      check_eq("rst_vld", 32'(bus0.dout_vld), 32'd0);
      check_eq("rst_dout", 32'(bus0.dout), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("idle_rdy", 32'({bus0.rdy, bus1.rdy}), 32'd3);
         check_eq("idle_vld", 32'({bus0.dout_vld, bus1.dout_vld}), 32'd0);
      end
      check_eq("idle_nostrobe", 32'(q0_nib.size() + q1_nib.size()), 32'd0);

      // 2/3/4: A13C on both DUTs, FFFF pulsed while busy
      wait_rdy0();
      clear_q();
      k = cyc;
      bus0.din = 16'hA13C; bus0.din_vld = 1'b1;
      bus1.din = 16'hA13C; bus1.din_vld = 1'b1;
      @(negedge clk);
      bus0.din = 16'hFFFF; bus1.din = 16'hFFFF;
      @(negedge clk);
      bus0.din_vld = 1'b0; bus1.din_vld = 1'b0;
      @(negedge clk);
      bus0.din_vld = 1'b1; bus1.din_vld = 1'b1;
      @(negedge clk);
      bus0.din_vld = 1'b0; bus1.din_vld = 1'b0;
      repeat (40) @(negedge clk);
      $display("frame A13C accepted cycle %0d", k);
      exp8 = 32'h55D5A13C;
      check_eq("t2_count", 32'(q0_nib.size()), 32'd8);
      check_eq("t3_count", 32'(q1_nib.size()), 32'd8);
      for (int j = 0; j < 8; j++) begin
         if (j < q0_nib.size()) begin
            check_eq("t2_nib", 32'(q0_nib[j]), 32'(exp8[(7-j)*4 +: 4]));
            check_eq("t2_cyc", 32'(q0_cyc[j]), 32'(k + 1 + j));
         end
         if (j < q1_nib.size()) begin
            check_eq("t3_nib", 32'(q1_nib[j]), 32'(exp8[(7-j)*4 +: 4]));
            check_eq("t3_cyc", 32'(q1_cyc[j]), 32'(k + 1 + 3*j));
         end
      end
      check_eq("t2_rdy_cyc", 32'(rise0), 32'(k + 13));
      check_eq("t3_rdy_cyc", 32'(rise1), 32'(k + 27));
      check_eq("t2_gap_zero", 32'(gap_bad0), 32'd0);
      check_eq("t3_gap_zero", 32'(gap_bad1), 32'd0);

      // 5: din_vld held high for two back-to-back frames
      wait_rdy0();
      clear_q();
      k = cyc;
      bus0.din = 16'h1234; bus0.din_vld = 1'b1;
      @(negedge clk);
      bus0.din = 16'h5678;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus0.rdy) break;
      end
      check_eq("t5_second_accept", 32'(bus0.rdy), 32'd1);
      @(negedge clk);
      bus0.din_vld = 1'b0;
      repeat (20) @(negedge clk);
      $display("frames 1234/5678 first accepted cycle %0d", k);
      exp16 = 64'h55D5123455D55678;
      check_eq("t5_count", 32'(q0_nib.size()), 32'd16);
      for (int j = 0; j < 16 && j < q0_nib.size(); j++) begin
         check_eq("t5_nib", 32'(q0_nib[j]), 32'(exp16[(15-j)*4 +: 4]));
         check_eq("t5_cyc", 32'(q0_cyc[j]), 32'((j < 8) ? k + 1 + j : k + 14 + (j - 8)));
      end
      if (q0_cyc.size() >= 9)
         check_eq("t5_idle_gap", 32'(q0_cyc[8] - q0_cyc[7] - 1), 32'd5);

      // 6: reset after the third nibble, then a clean 00FF frame
      wait_rdy0();
      clear_q();
      k = cyc;
      bus0.din = 16'hA13C; bus0.din_vld = 1'b1;
      @(negedge clk);
      bus0.din_vld = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_vld", 32'(bus0.dout_vld), 32'd0);
      check_eq("t6_rst_dout", 32'(bus0.dout), 32'd0);
      check_eq("t6_rst_rdy", 32'(bus0.rdy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("t6_abort_count", 32'(q0_nib.size()), 32'd3);
      @(negedge clk);
      check_eq("t6_post_rdy", 32'(bus0.rdy), 32'd1);
      clear_q();
      k = cyc;
      bus0.din = 16'h00FF; bus0.din_vld = 1'b1;
      @(negedge clk);
      bus0.din_vld = 1'b0;
      repeat (20) @(negedge clk);
      $display("frame 00FF accepted cycle %0d", k);
      exp8 = 32'h55D500FF;
      check_eq("t6_count", 32'(q0_nib.size()), 32'd8);
      for (int j = 0; j < 8 && j < q0_nib.size(); j++) begin
         check_eq("t6_nib", 32'(q0_nib[j]), 32'(exp8[(7-j)*4 +: 4]));
         check_eq("t6_cyc", 32'(q0_cyc[j]), 32'(k + 1 + j));
      end
      if (q0_nib.size() == 8) begin
         check_eq("t6_rx_byte0", 32'(q0_nib[4]*16 + q0_nib[5]), 32'h00);
         check_eq("t6_rx_byte1", 32'(q0_nib[6]*16 + q0_nib[7]), 32'hFF);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
